tx_arbiter: RTL

Round-robin arbiter and sequencer sharing the single `byte_ser` → `uart` transmit path between up to four message sources, such as the test engine and a register/PC dump unit. It sits in `top` between the requesters and the serializer's `din` / `din_bytecount` / `shift_begin` inputs. It watches the serializer's `empty` flag so that each message is fully drained before the next one is launched.

---
 rtl/tx_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/tx_arbiter.sv
// Round-robin arbiter that shares one byte_ser/uart transmit path between NREQ message sources.
// Optional watchdog on the serializer drain enabled by defining TX_ARB_TIMEOUT_EN.
module tx_arbiter #(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*256-1:0] req_d,
  input  logic [NREQ*4-1:0]   req_bytecount,
  output logic [NREQ-1:0]     ack,
  output logic [NREQ-1:0]     done,
  output logic [255:0]        ser_d,
  output logic [3:0]          ser_bytecount,
  output logic                ser_begin,
  input  logic                ser_empty,
  output logic                busy,
  output logic                timeout,
  output logic [1:0]          state_dbg
);

  // Handshake: a requester holds req with a stable payload until it sees ack
  // (a one-cycle pulse at capture); done pulses once the serializer has drained.

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE} state_t;

  if (NREQ < 1 || NREQ > 4) begin : g_bad_nreq
    $error("tx_arbiter: NREQ must be 1..4");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("tx_arbiter: TIMEOUT_CYCLES must be >= 1");
  end

  state_t      state;
  logic [1:0]  rr_ptr;
  logic [1:0]  owner;

  logic [3:0]   req4;
  logic         found;
  logic [1:0]   win;
  logic [255:0] win_d;
  logic [3:0]   win_cnt;

  assign state_dbg = state;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    if (p == 2'(NREQ - 1)) return 2'd0;
    return p + 2'd1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [1:0] p);
    logic [NREQ-1:0] o;
    o    = '0;
    o[0] = 1'b1;
    return o << p;
  endfunction

  // A requester whose zero-count ack is pulsing this cycle is masked so the
  // still-high req it is about to drop does not earn a second grant.
  always_comb begin
    req4            = '0;
    req4[NREQ-1:0]  = req & ~ack;
  end

  always_comb begin
    logic [2:0] s;
    found = 1'b0;
    win   = '0;
    s     = '0;
    for (int k = 0; k < NREQ; k++) begin
      s = {1'b0, rr_ptr} + 3'(k);
      if (s >= 3'(NREQ)) s = s - 3'(NREQ);
      if (!found && req4[s[1:0]]) begin
        found = 1'b1;
        win   = s[1:0];
      end
    end
  end

  always_comb begin
    win_d   = '0;
    win_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == 2'(i)) begin
        win_d   = req_d[i*256 +: 256];
        win_cnt = req_bytecount[i*4 +: 4];
      end
    end
  end

`ifdef TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt;
  logic          wd_hit;
  assign wd_hit = (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      ack           <= '0;
      done          <= '0;
      ser_begin     <= 1'b0;
      busy          <= 1'b0;
      ser_d         <= '0;
      ser_bytecount <= '0;
`ifdef TX_ARB_TIMEOUT_EN
      timeout       <= 1'b0;
      wd_cnt        <= '0;
`endif
    end else begin
      ack       <= '0;
      done      <= '0;
      ser_begin <= 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
      timeout   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            if (win_cnt != 4'd0) begin
              ser_d         <= win_d;
              ser_bytecount <= win_cnt;
              owner         <= win;
              ack           <= onehot(win);
              ser_begin     <= 1'b1;
              busy          <= 1'b1;
              state         <= LAUNCH;
            end else begin
              // Empty message: complete it on the spot without touching the serializer.
              ack    <= onehot(win);
              done   <= onehot(win);
              rr_ptr <= next_ptr(win);
            end
          end
        end
        LAUNCH: begin
          state <= WAIT_START;
`ifdef TX_ARB_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        WAIT_START: begin
          if (!ser_empty) begin
            state <= WAIT_DONE;
`ifdef TX_ARB_TIMEOUT_EN
            wd_cnt <= '0;
          end else if (wd_hit) begin
            timeout <= 1'b1;
            done    <= onehot(owner);
            rr_ptr  <= next_ptr(owner);
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end
        WAIT_DONE: begin
          if (ser_empty) begin
            done   <= onehot(owner);
            rr_ptr <= next_ptr(owner);
            busy   <= 1'b0;
            state  <= IDLE;
`ifdef TX_ARB_TIMEOUT_EN
          end else if (wd_hit) begin
            timeout <= 1'b1;
            done    <= onehot(owner);
            rr_ptr  <= next_ptr(owner);
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef TX_ARB_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

endmodule
